avmm_burst_reader: RTL and testbench

- Parametrised Avalon-MM burst read master. Fetches a contiguous word range from SDRAM and presents it as a valid/ready stream with sop/eop to the inference datapath.
- Successor to the fixed 16-bit SDRAM path in the system: data width, burst length and buffer depth are generalised.
- Adds flow-controlled prefetch, so there is never a readdatavalid overflow.
- Sits between the inference engine's command logic and the SDRAM controller's Avalon-MM slave port.

---
 rtl/avmm_burst_reader_if.sv | 40 ++++
 rtl/avmm_burst_reader.sv | 148 ++++++++++++++
 tb/tb_avmm_burst_reader.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/avmm_burst_reader_if.sv
// avmm_burst_reader_if: command, Avalon-MM burst read and stream bundle for avmm_burst_reader
// Ports (master = reader side):
//   cmd_valid/cmd_ready/cmd_addr/cmd_len           command handshake (byte address, length in words)
//   avm_address/avm_read/avm_burstcount            burst read request, held while avm_waitrequest
//   avm_waitrequest/avm_readdata/avm_readdatavalid slave stall and returned data
//   src_data/src_valid/src_ready/src_sop/src_eop   output word stream
//   busy/done                                      transfer status
interface avmm_burst_reader_if #(
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 32,
  parameter int LEN_W     = 24,
  parameter int MAX_BURST = 8
);
  localparam int BC_W = $clog2(MAX_BURST) + 1;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [ADDR_W-1:0] cmd_addr;
  logic [LEN_W-1:0]  cmd_len;
  logic [ADDR_W-1:0] avm_address;
  logic              avm_read;
  logic [BC_W-1:0]   avm_burstcount;
  logic              avm_waitrequest;
  logic [DATA_W-1:0] avm_readdata;
  logic              avm_readdatavalid;
  logic [DATA_W-1:0] src_data;
  logic              src_valid;
  logic              src_ready;
  logic              src_sop;
  logic              src_eop;
  logic              busy;
  logic              done;
  modport master (
    input  cmd_valid, cmd_addr, cmd_len, avm_waitrequest, avm_readdata, avm_readdatavalid, src_ready,
    output cmd_ready, avm_address, avm_read, avm_burstcount, src_data, src_valid, src_sop, src_eop, busy, done
  );
  modport slave (
    output cmd_valid, cmd_addr, cmd_len, avm_waitrequest, avm_readdata, avm_readdatavalid, src_ready,
    input  cmd_ready, avm_address, avm_read, avm_burstcount, src_data, src_valid, src_sop, src_eop, busy, done
  );
endinterface

// File: rtl/avmm_burst_reader.sv
// avmm_burst_reader: Avalon-MM burst read master streaming a contiguous word range with sop/eop
// Ports: clock_clk, clock_reset_reset (async, active-high), bus (avmm_burst_reader_if.master:
//   command handshake, Avalon-MM burst read master, valid/ready stream, busy/done status).
// Optional: define AVMM_BURST_ALIGN_EN to keep bursts inside MAX_BURST*DATA_W/8 byte-aligned blocks.
module avmm_burst_reader #(
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 32,
  parameter int LEN_W      = 24,
  parameter int MAX_BURST  = 8,
  parameter int FIFO_DEPTH = 64
) (
  input logic clock_clk,
  input logic clock_reset_reset,
  avmm_burst_reader_if.master bus
);
  localparam int BYTES = DATA_W / 8;
  localparam int BC_W  = $clog2(MAX_BURST) + 1;
  localparam int OW    = $clog2(FIFO_DEPTH) + 1;
  localparam int CW    = OW + 1;
  localparam int AW    = FIFO_DEPTH > 1 ? $clog2(FIFO_DEPTH) : 1;
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;
  state_t            state;
  logic [LEN_W-1:0]  left, len_r, ld_cnt, left_nxt;
  logic [LEN_W-1:0]  room_cmd, room_cur, room_nxt;
  logic [OW-1:0]     outst, mcnt;
  logic [AW-1:0]     wp, rp;
  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [ADDR_W-1:0] addr_nxt;
  logic [BC_W-1:0]   b_cmd, b_cur, b_nxt;
  logic [CW-1:0]     credit;
  logic              accept, issue, push, pop, out_free, from_mem, ld, mem_wr;
  function automatic logic [BC_W-1:0] bsize(input logic [LEN_W-1:0] r, input logic [LEN_W-1:0] n);
    return n < r ? BC_W'(n) : BC_W'(r);
  endfunction
`ifdef AVMM_BURST_ALIGN_EN
  function automatic logic [LEN_W-1:0] room(input logic [ADDR_W-1:0] a);
    return LEN_W'(MAX_BURST) - LEN_W'((a / ADDR_W'(BYTES)) % ADDR_W'(MAX_BURST));
  endfunction
  assign room_cmd = room(bus.cmd_addr);
  assign room_cur = room(bus.avm_address);
  assign room_nxt = room(addr_nxt);
`else
  assign room_cmd = LEN_W'(MAX_BURST);
  assign room_cur = room_cmd;
  assign room_nxt = room_cmd;
`endif
  assign accept   = bus.cmd_valid && bus.cmd_ready;
  assign issue    = bus.avm_read && !bus.avm_waitrequest;
  // words arriving with nothing outstanding belong to an aborted transfer
  assign push     = bus.avm_readdatavalid && outst != '0;
  assign pop      = bus.src_valid && bus.src_ready;
  assign out_free = !bus.src_valid || pop;
  assign from_mem = out_free && mcnt != '0;
  assign ld       = from_mem || (out_free && push);
  assign mem_wr   = push && !(out_free && mcnt == '0);
  // the output register counts as a buffer slot, so credit covers it too
  assign credit   = CW'(FIFO_DEPTH) - CW'(mcnt) - CW'(bus.src_valid) - CW'(outst);
  assign left_nxt = left - LEN_W'(bus.avm_burstcount);
  assign addr_nxt = bus.avm_address + ADDR_W'(bus.avm_burstcount) * ADDR_W'(BYTES);
  assign b_cmd    = bsize(room_cmd, bus.cmd_len);
  assign b_cur    = bsize(room_cur, left);
  assign b_nxt    = bsize(room_nxt, left_nxt);
  always_ff @(posedge clock_clk or posedge clock_reset_reset)
    if (clock_reset_reset) begin
      state              <= IDLE;
      bus.cmd_ready      <= 1'b1;
      bus.avm_read       <= 1'b0;
      bus.avm_address    <= '0;
      bus.avm_burstcount <= '0;
      bus.busy           <= 1'b0;
      bus.done           <= 1'b0;
      left               <= '0;
      len_r              <= '0;
      outst              <= '0;
    end else begin
      bus.done <= 1'b0;
      outst    <= outst + (issue ? OW'(bus.avm_burstcount) : OW'(0)) - OW'(push);
      case (state)
        IDLE:
          if (accept) begin
            len_r           <= bus.cmd_len;
            left            <= bus.cmd_len;
            bus.avm_address <= bus.cmd_addr;
            if (bus.cmd_len == '0) bus.done <= 1'b1;
            else begin
              state              <= ISSUE;
              bus.cmd_ready      <= 1'b0;
              bus.busy           <= 1'b1;
              bus.avm_read       <= credit >= CW'(b_cmd);
              bus.avm_burstcount <= b_cmd;
            end
          end
        ISSUE:
          if (issue) begin
            bus.avm_address <= addr_nxt;
            left            <= left_nxt;
            if (left_nxt == '0) begin
              bus.avm_read <= 1'b0;
              state        <= DRAIN;
            end else begin
              // back-to-back only if credit still suffices once this burst is charged
              bus.avm_read       <= credit - CW'(bus.avm_burstcount) >= CW'(b_nxt);
              bus.avm_burstcount <= b_nxt;
            end
          end else if (!bus.avm_read && credit >= CW'(b_cur)) begin
            bus.avm_read       <= 1'b1;
            bus.avm_burstcount <= b_cur;
          end
        default:
          if (pop && bus.src_eop) begin
            state         <= IDLE;
            bus.cmd_ready <= 1'b1;
            bus.busy      <= 1'b0;
            bus.done      <= 1'b1;
          end
      endcase
    end
  // show-ahead buffer: memory plus a registered output stage, bypassed when the memory is empty
  always_ff @(posedge clock_clk or posedge clock_reset_reset)
    if (clock_reset_reset) begin
      wp            <= '0;
      rp            <= '0;
      mcnt          <= '0;
      ld_cnt        <= '0;
      bus.src_valid <= 1'b0;
      bus.src_data  <= '0;
      bus.src_sop   <= 1'b0;
      bus.src_eop   <= 1'b0;
    end else begin
      if (mem_wr) wp <= wp + AW'(1);
      if (from_mem) rp <= rp + AW'(1);
      mcnt <= mcnt + OW'(mem_wr) - OW'(from_mem);
      if (accept) ld_cnt <= '0;
      else if (ld) ld_cnt <= ld_cnt + LEN_W'(1);
      if (ld) begin
        bus.src_valid <= 1'b1;
        bus.src_data  <= from_mem ? mem[rp] : bus.avm_readdata;
        bus.src_sop   <= ld_cnt == '0;
        bus.src_eop   <= ld_cnt == len_r - LEN_W'(1);
      end else if (pop) begin
        bus.src_valid <= 1'b0;
        bus.src_sop   <= 1'b0;
        bus.src_eop   <= 1'b0;
      end
    end
  always_ff @(posedge clock_clk)
    if (mem_wr) mem[wp] <= bus.avm_readdata;
endmodule

// File: tb/tb_avmm_burst_reader.sv
// tb_avmm_burst_reader: directed self-checking bench for avmm_burst_reader with a modelled SDRAM slave
module tb_avmm_burst_reader;
  localparam int DW = 16, AW = 32, LW = 24, MB = 8, FD = 16;
  logic clk = 1'b0, rst = 1'b1;
  int errors = 0, checks = 0;
  int cyc = 0, stall = 0, stall_seen, unstable, done_cnt, done_cyc, eop_cyc, acc_cyc, busy_cyc, first_rd_cyc;
  int busy_at_done, st_addr, st_bc;
  int b_addr[$], b_len[$], pend_a[$], pend_t[$];
  int w_data[$];
  bit w_sop[$], w_eop[$];
  always #5 clk = ~clk;
  avmm_burst_reader_if #(.DATA_W(DW), .ADDR_W(AW), .LEN_W(LW), .MAX_BURST(MB)) bus ();
  avmm_burst_reader #(.DATA_W(DW), .ADDR_W(AW), .LEN_W(LW), .MAX_BURST(MB), .FIFO_DEPTH(FD)) dut (
    .clock_clk(clk),
    .clock_reset_reset(rst),
    .bus(bus)
  );
  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask
  // slave model and stream monitor, all sampled on the falling edge
  initial begin
    bus.avm_waitrequest = 1'b0;
    bus.avm_readdatavalid = 1'b0;
    bus.avm_readdata = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (bus.busy) busy_cyc++;
      if (bus.cmd_valid && bus.cmd_ready) acc_cyc = cyc;
      if (bus.done) begin
        done_cnt++;
        done_cyc = cyc;
        busy_at_done = int'(bus.busy);
      end
      if (bus.src_valid && bus.src_ready) begin
        w_data.push_back(int'(bus.src_data));
        w_sop.push_back(bus.src_sop);
        w_eop.push_back(bus.src_eop);
        if (bus.src_eop) eop_cyc = cyc;
      end
      if (bus.avm_read && first_rd_cyc == 0) first_rd_cyc = cyc;
      bus.avm_waitrequest = bus.avm_read && stall > 0;
      if (bus.avm_waitrequest) begin
        stall--;
        stall_seen++;
        if (stall_seen == 1) begin
          st_addr = int'(bus.avm_address);
          st_bc = int'(bus.avm_burstcount);
        end else if (int'(bus.avm_address) != st_addr || int'(bus.avm_burstcount) != st_bc) unstable++;
      end
      if (bus.avm_read && !bus.avm_waitrequest) begin
        b_addr.push_back(int'(bus.avm_address));
        b_len.push_back(int'(bus.avm_burstcount));
        for (int i = 0; i < int'(bus.avm_burstcount); i++) begin
          pend_a.push_back(int'(bus.avm_address) + 2 * i);
          pend_t.push_back(cyc + 2);
        end
      end
      if (pend_a.size() > 0 && pend_t[0] <= cyc) begin
        bus.avm_readdatavalid = 1'b1;
        bus.avm_readdata = DW'(pend_a.pop_front() >> 1);
        void'(pend_t.pop_front());
      end else bus.avm_readdatavalid = 1'b0;
    end
  end
  task automatic clear();
    b_addr.delete(); b_len.delete(); w_data.delete(); w_sop.delete(); w_eop.delete();
    stall_seen = 0; unstable = 0; done_cnt = 0; done_cyc = 0; eop_cyc = 0; acc_cyc = 0;
    busy_cyc = 0; first_rd_cyc = 0; busy_at_done = 0;
  endtask
  task automatic send(input int a, input int n, input string tag);
    bit ok = 1'b0;
    bus.cmd_addr = AW'(a);
    bus.cmd_len = LW'(n);
    bus.cmd_valid = 1'b1;
    for (int t = 0; t < 50 && !ok; t++) begin
      @(negedge clk);
      #1;
      ok = bus.cmd_ready;
    end
    @(posedge clk);
    #2;
    bus.cmd_valid = 1'b0;
    chk({tag, "_accept"}, int'(ok), 1);
  endtask
  task automatic wait_done(input int budget, input string tag);
    int t = 0;
    while (done_cnt == 0 && t < budget) begin
      @(posedge clk);
      t++;
    end
    repeat (3) @(posedge clk);
    #2;
    chk({tag, "_done_seen"}, int'(done_cnt != 0), 1);
  endtask
  task automatic check_burst(input string tag, input int idx, input int a, input int n);
    if (idx < b_len.size()) begin
      chk({tag, "_baddr"}, b_addr[idx], a);
      chk({tag, "_blen"}, b_len[idx], n);
    end else chk({tag, "_bmissing"}, idx - b_len.size(), -1);
  endtask
  task automatic check_words(input string tag, input int base, input int n);
    int bad = 0, sops = 0, eops = 0;
    chk({tag, "_nwords"}, w_data.size(), n);
    foreach (w_data[i]) begin
      if (w_data[i] != ((base + i) & 32'hffff)) bad++;
      if (w_sop[i] != (i == 0)) sops++;
      if (w_eop[i] != (i == n - 1)) eops++;
    end
    chk({tag, "_bad_data"}, bad, 0);
    chk({tag, "_bad_sop"}, sops, 0);
    chk({tag, "_bad_eop"}, eops, 0);
    chk({tag, "_done_cnt"}, done_cnt, 1);
    chk({tag, "_done_lat"}, done_cyc - eop_cyc, 1);
    chk({tag, "_busy_at_done"}, busy_at_done, 0);
    chk({tag, "_cmd_ready"}, int'(bus.cmd_ready), 1);
  endtask
  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_addr = '0;
    bus.cmd_len = '0;
    bus.src_ready = 1'b1;
    clear();
    repeat (3) @(posedge clk);
    #2;
    chk("rst_cmd_ready", int'(bus.cmd_ready), 1);
    chk("rst_avm_read", int'(bus.avm_read), 0);
    chk("rst_src_valid", int'(bus.src_valid), 0);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_done", int'(bus.done), 0);
    rst = 1'b0;
    @(posedge clk);
    #2;
    // 20 words from 0x100: bursts 8, 8, 4
    clear();
    send(32'h100, 20, "t1");
    wait_done(400, "t1");
    chk("t1_nburst", b_len.size(), 3);
    check_burst("t1_b0", 0, 32'h100, 8);
    check_burst("t1_b1", 1, 32'h110, 8);
    check_burst("t1_b2", 2, 32'h120, 4);
    chk("t1_first_read_lat", first_rd_cyc - acc_cyc, 1);
    check_words("t1", 32'h80, 20);
    // zero length: done only
    clear();
    send(32'h40, 0, "t2");
    repeat (5) @(posedge clk);
    #2;
    chk("t2_done_cnt", done_cnt, 1);
    chk("t2_done_lat", done_cyc - acc_cyc, 1);
    chk("t2_nburst", b_len.size(), 0);
    chk("t2_first_read", first_rd_cyc, 0);
    chk("t2_busy_cycles", busy_cyc, 0);
    // backpressure: only a buffer's worth is requested
    clear();
    bus.src_ready = 1'b0;
    send(0, 64, "t3");
    repeat (40) @(posedge clk);
    #2;
    begin
      int req = 0;
      foreach (b_len[i]) req += b_len[i];
      chk("t3_words_requested", req, 16);
    end
    chk("t3_nburst_held", b_len.size(), 2);
    chk("t3_read_low", int'(bus.avm_read), 0);
    chk("t3_src_valid", int'(bus.src_valid), 1);
    bus.src_ready = 1'b1;
    wait_done(2000, "t3");
    chk("t3_nburst", b_len.size(), 8);
    check_burst("t3_b7", 7, 32'h70, 8);
    check_words("t3", 0, 64);
    // waitrequest for 5 cycles on the first burst
    clear();
    stall = 5;
    send(32'h200, 8, "t4");
    wait_done(400, "t4");
    chk("t4_stall_cycles", stall_seen, 5);
    chk("t4_unstable", unstable, 0);
    chk("t4_nburst", b_len.size(), 1);
    check_burst("t4_b0", 0, 32'h200, 8);
    check_words("t4", 32'h100, 8);
    // reset in DRAIN with 3 words outstanding
    clear();
    send(32'h280, 3, "t5");
    begin
      int t = 0;
      while (b_len.size() == 0 && t < 20) begin
        @(posedge clk);
        #2;
        t++;
      end
    end
    chk("t5_burst_issued", b_len.size(), 1);
    rst = 1'b1;
    #1;
    chk("t5_rst_cmd_ready", int'(bus.cmd_ready), 1);
    chk("t5_rst_avm_read", int'(bus.avm_read), 0);
    chk("t5_rst_busy", int'(bus.busy), 0);
    chk("t5_rst_src_valid", int'(bus.src_valid), 0);
    chk("t5_rst_done", int'(bus.done), 0);
    @(posedge clk);
    #2;
    rst = 1'b0;
    clear();
    repeat (8) @(posedge clk);
    #2;
    chk("t5_late_words", w_data.size(), 0);
    chk("t5_late_valid", int'(bus.src_valid), 0);
    chk("t5_late_pending", pend_a.size(), 0);
    chk("t5_late_done", done_cnt, 0);
    clear();
    send(32'h300, 4, "t5b");
    wait_done(400, "t5b");
    chk("t5b_nburst", b_len.size(), 1);
    check_burst("t5b_b0", 0, 32'h300, 4);
    check_words("t5b", 32'h180, 4);
    // unaligned start address
    clear();
    send(32'hA, 10, "t6");
    wait_done(400, "t6");
    chk("t6_nburst", b_len.size(), 2);
`ifdef AVMM_BURST_ALIGN_EN
    check_burst("t6_b0", 0, 32'hA, 3);
    check_burst("t6_b1", 1, 32'h10, 7);
`else
    check_burst("t6_b0", 0, 32'hA, 8);
    check_burst("t6_b1", 1, 32'h1A, 2);
`endif
    check_words("t6", 5, 10);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end
endmodule
